control_sequencer: RTL and testbench



---
 rtl/control_sequencer.sv | 175 +++++++++++++++++
 tb/tb_control_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for the shared-bus datapath.
// Strobes are decoded from the state register and the latched opcode.
module control_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] ir_value,
  input  logic              con_ff,
  input  logic              mem_ready,
  output logic              pc_out,
  output logic              mar_in,
  output logic              inc_pc,
  output logic              z_in,
  output logic              zlow_out,
  output logic              pc_in,
  output logic              read,
  output logic              write,
  output logic              mdr_in,
  output logic              mdr_out,
  output logic              ir_in,
  output logic              y_in,
  output logic              gra,
  output logic              grb,
  output logic              grc,
  output logic              r_in,
  output logic              r_out,
  output logic              ba_out,
  output logic              c_out,
  output logic              con_in,
  output logic [3:0]        alu_op,
  output logic              run,
  output logic              illegal
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic [4:0] w_opcode;
  logic       w_rtype;
  logic       w_mem;
  logic       w_legal;

  assign w_opcode = ir_value[DATA_W-1 -: 5];
  assign w_rtype  = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                    (w_opcode == OP_AND) || (w_opcode == OP_OR);
  assign w_mem    = (w_opcode == OP_LD) || (w_opcode == OP_ST);
  assign w_legal  = w_rtype || w_mem || (w_opcode == OP_ADDI) || (w_opcode == OP_BR) ||
                    (w_opcode == OP_NOP) || (w_opcode == OP_HALT);
  assign illegal  = r_illegal;

  function automatic logic [3:0] alu_sel(input logic [4:0] op);
    case (op)
      OP_SUB:  alu_sel = 4'd1;
      OP_AND:  alu_sel = 4'd2;
      OP_OR:   alu_sel = 4'd3;
      default: alu_sel = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_RST;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      // Sticky: only reset clears it, HALT never revisits T3.
      if (r_state == S_T3 && !w_legal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    pc_out   = 1'b0; mar_in  = 1'b0; inc_pc = 1'b0; z_in   = 1'b0;
    zlow_out = 1'b0; pc_in   = 1'b0; read   = 1'b0; write  = 1'b0;
    mdr_in   = 1'b0; mdr_out = 1'b0; ir_in  = 1'b0; y_in   = 1'b0;
    gra      = 1'b0; grb     = 1'b0; grc    = 1'b0; r_in   = 1'b0;
    r_out    = 1'b0; ba_out  = 1'b0; c_out  = 1'b0; con_in = 1'b0;
    alu_op   = 4'd0;
    run      = (r_state != S_RST) && (r_state != S_HALT);
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
        w_next = mem_ready ? S_T2 : S_T1W;
      end
      S_T1W: begin
        read = 1'b1; mdr_in = 1'b1;
        w_next = mem_ready ? S_T2 : S_T1W;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        w_next = S_T4;
        if (w_rtype || w_opcode == OP_ADDI) begin
          grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
        end else if (w_mem) begin
          grb = 1'b1; ba_out = 1'b1; y_in = 1'b1;
        end else if (w_opcode == OP_BR) begin
          gra = 1'b1; r_out = 1'b1; con_in = 1'b1;
        end else if (w_opcode == OP_NOP) begin
          w_next = S_T0;
        end else begin
          w_next = S_HALT;
        end
      end
      S_T4: begin
        w_next = S_T5;
        if (w_rtype) begin
          grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_sel(w_opcode);
        end else if (w_mem || w_opcode == OP_ADDI) begin
          c_out = 1'b1; z_in = 1'b1;
        end else if (w_opcode == OP_BR) begin
          pc_out = 1'b1; y_in = 1'b1;
        end else begin
          w_next = S_T0;
        end
      end
      S_T5: begin
        w_next = S_T0;
        if (w_rtype || w_opcode == OP_ADDI) begin
          zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (w_mem) begin
          zlow_out = 1'b1; mar_in = 1'b1; w_next = S_T6;
        end else if (w_opcode == OP_BR) begin
          c_out = 1'b1; z_in = 1'b1; w_next = S_T6;
        end
      end
      S_T6: begin
        w_next = S_T0;
        if (w_opcode == OP_LD) begin
          read = 1'b1; mdr_in = 1'b1;
          w_next = mem_ready ? S_T7 : S_T6;
        end else if (w_opcode == OP_ST) begin
          gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; w_next = S_T7;
        end else if (w_opcode == OP_BR) begin
          zlow_out = 1'b1; pc_in = con_ff;
        end
      end
      S_T7: begin
        w_next = S_T0;
        if (w_opcode == OP_LD) begin
          mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (w_opcode == OP_ST) begin
          write = 1'b1;
          w_next = mem_ready ? S_T0 : S_T7;
        end
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes expected strobe vectors per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_sequencer;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [DATA_W-1:0] ir_value = '0;
  logic con_ff = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, write, mdr_in, mdr_out;
  logic ir_in, y_in, gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, run, illegal;
  logic [3:0] alu_op;

  control_sequencer #(.DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .ir_value(ir_value), .con_ff(con_ff), .mem_ready(mem_ready),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in), .zlow_out(zlow_out),
    .pc_in(pc_in), .read(read), .write(write), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .y_in(y_in), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
    .ba_out(ba_out), .c_out(c_out), .con_in(con_in), .alu_op(alu_op), .run(run),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  localparam logic [25:0] PO  = 26'd1 << 0,  MI  = 26'd1 << 1,  IP  = 26'd1 << 2;
  localparam logic [25:0] ZI  = 26'd1 << 3,  ZO  = 26'd1 << 4,  PI  = 26'd1 << 5;
  localparam logic [25:0] RD  = 26'd1 << 6,  WR  = 26'd1 << 7,  MDI = 26'd1 << 8;
  localparam logic [25:0] MDO = 26'd1 << 9,  IRI = 26'd1 << 10, YI  = 26'd1 << 11;
  localparam logic [25:0] GA  = 26'd1 << 12, GB  = 26'd1 << 13, GC  = 26'd1 << 14;
  localparam logic [25:0] RI  = 26'd1 << 15, RO  = 26'd1 << 16, BAO = 26'd1 << 17;
  localparam logic [25:0] CO  = 26'd1 << 18, CI  = 26'd1 << 19;
  localparam logic [25:0] RUN = 26'd1 << 24, ILL = 26'd1 << 25;

  localparam logic [4:0] LD = 5'b00000, ST = 5'b00010, ADD = 5'b00011, SUB = 5'b00100;
  localparam logic [4:0] ANDOP = 5'b00101, OROP = 5'b00110, ADDI = 5'b01100;
  localparam logic [4:0] BR = 5'b10010, NOP = 5'b11010, HALT = 5'b11011;

  logic [25:0] w_obs;
  assign w_obs = {illegal, run, alu_op, con_in, c_out, ba_out, r_out, r_in, grc, grb, gra,
                  y_in, ir_in, mdr_out, mdr_in, write, read, pc_in, zlow_out, z_in, inc_pc,
                  mar_in, pc_out};

  typedef struct {
    logic [25:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (w_obs !== cur.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", cur.nm, w_obs, cur.v);
      end
      checks++;
      if ((read & write) !== 1'b0) begin
        errors++;
        $display("FAIL rd_wr_excl at %s: got read=%b write=%b required not both 1", cur.nm, read, write);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [25:0] alu_mask(input logic [4:0] op);
    int a;
    a = (op == SUB) ? 1 : (op == ANDOP) ? 2 : (op == OROP) ? 3 : 0;
    return 26'(a) << 20;
  endfunction

  function automatic bit is_legal(input logic [4:0] op);
    return op inside {LD, ST, ADD, SUB, ANDOP, OROP, ADDI, BR, NOP, HALT};
  endfunction

  task automatic step(input logic [25:0] e, input logic mr, input string nm);
    mem_ready = mr;
    exp_q.push_back('{e, nm});
    @(posedge clock); #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = rnd();
    exp_q.push_back('{26'd0, "reset_a"}); @(posedge clock); #1;
    exp_q.push_back('{26'd0, "reset_b"}); @(posedge clock); #1;
    reset = 1'b0;
    exp_q.push_back('{26'd0, "reset_rel"}); @(posedge clock); #1;
  endtask

  // One instruction as the spec's step table; w1/wm are memory wait cycles in fetch/execute.
  task automatic run_instr(input logic [4:0] op, input logic con, input int w1, input int wm,
                           input bit abort);
    step(RUN | PO | MI | IP | ZI, rnd(), "T0");
    step(RUN | ZO | PI | RD | MDI, (w1 == 0), "T1");
    for (int k = 0; k < w1; k++) step(RUN | RD | MDI, (k == w1 - 1), "T1W");
    step(RUN | MDO | IRI, rnd(), "T2");
    ir_value = {op, 27'($urandom)};
    con_ff = con;
    if (op inside {ADD, SUB, ANDOP, OROP}) begin
      step(RUN | GB | RO | YI, rnd(), "R_T3");
      step(RUN | GC | RO | ZI | alu_mask(op), rnd(), "R_T4");
      step(RUN | ZO | GA | RI, rnd(), "R_T5");
    end else if (op == ADDI) begin
      step(RUN | GB | RO | YI, rnd(), "I_T3");
      step(RUN | CO | ZI, rnd(), "I_T4");
      step(RUN | ZO | GA | RI, rnd(), "I_T5");
    end else if (op == LD || op == ST) begin
      step(RUN | GB | BAO | YI, rnd(), "M_T3");
      step(RUN | CO | ZI, rnd(), "M_T4");
      step(RUN | ZO | MI, rnd(), "M_T5");
      if (op == LD) begin
        for (int k = 0; k < wm; k++) begin
          if (abort && k == 1) begin
            do_reset();
            return;
          end
          step(RUN | RD | MDI, 1'b0, "LD_T6W");
        end
        step(RUN | RD | MDI, 1'b1, "LD_T6");
        step(RUN | MDO | GA | RI, rnd(), "LD_T7");
      end else begin
        step(RUN | GA | RO | MDI, rnd(), "ST_T6");
        for (int k = 0; k < wm; k++) step(RUN | WR, 1'b0, "ST_T7W");
        step(RUN | WR, 1'b1, "ST_T7");
      end
    end else if (op == BR) begin
      step(RUN | GA | RO | CI, rnd(), "BR_T3");
      step(RUN | PO | YI, rnd(), "BR_T4");
      step(RUN | CO | ZI, rnd(), "BR_T5");
      step(RUN | ZO | (con ? PI : 26'd0), rnd(), "BR_T6");
    end else if (op == NOP) begin
      step(RUN, rnd(), "NOP_T3");
    end else if (op == HALT) begin
      step(RUN, rnd(), "HALT_T3");
      for (int k = 0; k < 5; k++) step(26'd0, rnd(), "HALTED");
    end else begin
      step(RUN, rnd(), "ILL_T3");
      for (int k = 0; k < 10; k++) step(ILL, rnd(), "ILL_HALTED");
    end
  endtask

  logic [4:0] ops[9] = '{LD, ST, ADD, SUB, ANDOP, OROP, ADDI, BR, NOP};
  logic [4:0] bad;

  initial begin
    @(posedge clock); #1;
    do_reset();
    run_instr(ADD, 1'b0, 0, 0, 1'b0);
    run_instr(NOP, 1'b0, 3, 0, 1'b0);
    run_instr(BR, 1'b0, 0, 0, 1'b0);
    run_instr(BR, 1'b1, 1, 0, 1'b0);
    run_instr(ST, 1'b0, 0, 2, 1'b0);
    run_instr(LD, 1'b1, 2, 1, 1'b0);
    run_instr(ADDI, 1'b0, 0, 0, 1'b0);
    run_instr(SUB, 1'b0, 0, 0, 1'b0);
    run_instr(ANDOP, 1'b1, 0, 0, 1'b0);
    run_instr(OROP, 1'b0, 0, 0, 1'b0);
    run_instr(5'b11111, 1'b0, 0, 0, 1'b0);
    do_reset();
    run_instr(LD, 1'b0, 0, 3, 1'b1);
    for (int n = 0; n < 40; n++) begin
      run_instr(ops[$urandom_range(0, 8)], rnd(), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b0);
    end
    run_instr(HALT, 1'b0, 0, 0, 1'b0);
    do_reset();
    do begin
      bad = 5'($urandom);
    end while (is_legal(bad));
    run_instr(bad, rnd(), $urandom_range(0, 2), 0, 1'b0);
    do_reset();
    run_instr(ADD, 1'b0, 0, 0, 1'b0);
    @(negedge clock); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
